// File: rtl/beep_seq_pkg.sv
// Shared types and timing constants for the beep sequencer and its ms tick.
package beep_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ACK,
        WAIT_END,
        GAP,
        DONE,
        DONE_ERR
    } seq_state_t;

    localparam int MS_DIV      = 4000;
    localparam int MS_DIV_SIM  = 10;
    localparam int ACK_TIMEOUT = 15;

    // Number of 4 MHz cycles that make up one (possibly shortened) millisecond.
    function automatic logic [11:0] msDivisor(input bit sim);
        return sim ? 12'(MS_DIV_SIM) : 12'(MS_DIV);
    endfunction

endpackage

// File: rtl/mod_beep_seq_ms_tick.sv
// Millisecond tick generator: one-cycle tick every MS divisor cycles since the last clear.
module mod_ms_tick
    import beep_seq_pkg::*;
#(
    parameter bit simulation = 1'b0
) (
    input  logic clk_4M_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [11:0] DIV_LAST = msDivisor(simulation) - 12'd1;

    logic [11:0] r_count;

    assign tick_o = !clr_i && (r_count == DIV_LAST);

    // Free-running divider that wraps after the last count and restarts on clear.
    always_ff @(posedge clk_4M_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clr_i || (r_count == DIV_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 12'd1;
        end
    end

endmodule

// File: rtl/mod_beep_seq.sv
// Beep sequencer: plays N fixed-length beeps on mod_buzzer with programmable silent gaps.
module mod_beep_seq
    import beep_seq_pkg::*;
#(
    parameter bit simulation = 1'b0,
    parameter int CNT_W      = 4
) (
    input  logic             clk_4M_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] beep_count_i,
    input  logic [31:0]      on_ms_i,
    input  logic [15:0]      gap_ms_i,
    input  logic             buzz_cyc_i,
    output logic             buzz_trig_o,
    output logic [31:0]      buzz_period_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] beeps_left_o
);

    localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

    seq_state_t       r_state;
    logic             r_trig;
    logic [31:0]      r_period;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_left;
    logic [15:0]      r_gap;
    logic [15:0]      r_gapCnt;
    logic [3:0]       r_ackCnt;
    logic             r_abort;

    logic w_tick;
    logic w_tickClr;
    logic w_abortSeen;

    assign w_tickClr   = (r_state != GAP);
    assign w_abortSeen = r_abort | abort_i;

    assign buzz_trig_o   = r_trig;
    assign buzz_period_o = r_period;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign beeps_left_o  = r_left;

    mod_ms_tick #(
        .simulation(simulation)
    ) u_msTick (
        .clk_4M_i(clk_4M_i),
        .rst_i   (rst_i),
        .clr_i   (w_tickClr),
        .tick_o  (w_tick)
    );

    // Sequencer FSM; the ack counter starts at 1 in TRIG so the trigger cycle counts toward the timeout.
    always_ff @(posedge clk_4M_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_trig   <= 1'b0;
            r_period <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_left   <= '0;
            r_gap    <= '0;
            r_gapCnt <= '0;
            r_ackCnt <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            r_done <= 1'b0;
            if (r_busy && abort_i) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_period <= on_ms_i;
                        r_gap    <= gap_ms_i;
                        r_left   <= beep_count_i;
                        r_err    <= 1'b0;
                        r_abort  <= 1'b0;
                        r_busy   <= 1'b1;
                        if (beep_count_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= TRIG;
                            r_trig  <= 1'b1;
                        end
                    end
                end
                TRIG: begin
                    if (r_left != '0) begin
                        r_left <= r_left - 1'b1;
                    end
                    r_ackCnt <= 4'd1;
                    r_state  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (buzz_cyc_i) begin
                        r_state <= WAIT_END;
                    end else if (r_ackCnt == ACK_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= DONE_ERR;
                    end else begin
                        r_ackCnt <= r_ackCnt + 4'd1;
                    end
                end
                WAIT_END: begin
                    if (!buzz_cyc_i) begin
                        if (w_abortSeen) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_left == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (r_gap == '0) begin
                            r_state <= TRIG;
                            r_trig  <= 1'b1;
                        end else begin
                            r_state  <= GAP;
                            r_gapCnt <= '0;
                        end
                    end
                end
                GAP: begin
                    if (w_abortSeen) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        if ((r_gapCnt + 16'd1) == r_gap) begin
                            r_state <= TRIG;
                            r_trig  <= 1'b1;
                        end else begin
                            r_gapCnt <= r_gapCnt + 16'd1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                DONE_ERR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_beep_seq.sv
// Self-checking bench for mod_beep_seq with a behavioural buzzer and an outcome-level reference model.
module tb_mod_beep_seq;

    localparam int CNT_W = 4;
    localparam int MS_CYC = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abortBuzz = 1'b0;
    logic             abortMain = 1'b0;
    logic             abortIn;
    logic [CNT_W-1:0] beepCount = '0;
    logic [31:0]      onMsIn = '0;
    logic [15:0]      gapMsIn = '0;
    logic             buzzCyc = 1'b0;
    logic             buzzTrig;
    logic [31:0]      buzzPeriod;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] beepsLeft;

    int  vectors = 0;
    int  miscompares = 0;
    int  cycleCount = 0;
    int  seqId = 0;
    int  fallSeq = -1;
    int  lastFallCycle = 0;
    int  lastTrigCycle = 0;
    int  trigTotal = 0;
    int  doneTotal = 0;
    int  curCount = 0;
    int  curGap = 0;
    int  abortBeep = 0;
    bit  buzzEnable = 1'b1;
    bit  prevErr = 1'b0;

    assign abortIn = abortBuzz | abortMain;

    mod_beep_seq #(
        .simulation(1'b1),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_4M_i     (clk),
        .rst_i        (rst),
        .start_i      (start),
        .abort_i      (abortIn),
        .beep_count_i (beepCount),
        .on_ms_i      (onMsIn),
        .gap_ms_i     (gapMsIn),
        .buzz_cyc_i   (buzzCyc),
        .buzz_trig_o  (buzzTrig),
        .buzz_period_o(buzzPeriod),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .beeps_left_o (beepsLeft)
    );

    // 4 MHz stand-in clock, 10 ns period.
    always #5 clk = ~clk;

    // Cycle index used to time trigger, fall and error events.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Behavioural buzzer: acks a trigger after a short random latency, stays high a few cycles,
    // and optionally pulses abort early in the chosen beep.
    initial begin : buzzerModel
        int beepNum;
        int mySeq;
        int lat;
        int hi;
        beepNum = 0;
        mySeq = -1;
        forever begin
            @(negedge clk);
            if (buzzTrig && buzzEnable) begin
                if (mySeq != seqId) begin
                    mySeq = seqId;
                    beepNum = 0;
                end
                beepNum++;
                lat = $urandom_range(0, 3);
                hi = $urandom_range(3, 8);
                repeat (lat) @(negedge clk);
                buzzCyc = 1'b1;
                for (int i = 0; i < hi; i++) begin
                    @(negedge clk);
                    if (i == 0 && beepNum == abortBeep) begin
                        abortBuzz = 1'b1;
                        checkOutput("leftAtAbort", beepsLeft, curCount - abortBeep);
                    end else begin
                        abortBuzz = 1'b0;
                    end
                end
                buzzCyc = 1'b0;
                lastFallCycle = cycleCount;
                fallSeq = seqId;
            end
        end
    end

    // Event monitor: counts triggers/done pulses, checks gap length and ack-timeout delay.
    initial begin : eventMonitor
        int diff;
        forever begin
            @(negedge clk);
            if (buzzTrig) begin
                trigTotal++;
                if (fallSeq == seqId) begin
                    diff = cycleCount - lastFallCycle;
                    checkOutput("gapWithinTol", (diff >= curGap * MS_CYC - 2 && diff <= curGap * MS_CYC + 2) ? 1 : 0, 1);
                    if (!(diff >= curGap * MS_CYC - 2 && diff <= curGap * MS_CYC + 2)) begin
                        $display("[TB] gap measured %0d cycles for gap_ms %0d", diff, curGap);
                    end
                end
                lastTrigCycle = cycleCount;
            end
            if (done) doneTotal++;
            if (err && !prevErr) begin
                checkOutput("errDelay", cycleCount - lastTrigCycle, 15);
            end
            prevErr = err;
        end
    end

    // Runs one start request to completion and compares against the expected outcome.
    task automatic applyStimulus(input int count, input logic [31:0] onMs, input int gap,
                                 input bit responsive, input int abortAt, input bit restart,
                                 input bit abortWithStart);
        int  trig0;
        int  done0;
        int  waited;
        bit  aborted;
        bit  timedOut;
        int  expTrig;
        int  expDone;
        int  expLeft;
        aborted  = responsive && count > 0 && abortAt > 0 && abortAt <= count;
        timedOut = !responsive && count > 0;
        expTrig  = (count == 0) ? 0 : timedOut ? 1 : aborted ? abortAt : count;
        expDone  = (count == 0 || !(aborted || timedOut)) ? 1 : 0;
        expLeft  = (count == 0) ? 0 : timedOut ? count - 1 : aborted ? count - abortAt : 0;

        seqId++;
        curCount = count;
        curGap = gap;
        abortBeep = aborted ? abortAt : 0;
        buzzEnable = responsive;
        trig0 = trigTotal;
        done0 = doneTotal;

        @(negedge clk);
        start = 1'b1;
        beepCount = CNT_W'(count);
        onMsIn = onMs;
        gapMsIn = 16'(gap);
        abortMain = abortWithStart;
        @(negedge clk);
        start = 1'b0;
        abortMain = 1'b0;
        beepCount = CNT_W'($urandom);
        gapMsIn = 16'($urandom_range(0, 5));
        onMsIn = ~onMs;

        checkOutput("busyAtStart", busy, 1);
        checkOutput("trigAtStart", buzzTrig, (count > 0) ? 1 : 0);
        checkOutput("doneAtStart", done, (count == 0) ? 1 : 0);
        checkOutput("errCleared", err, 0);
        checkOutput("periodLatched", buzzPeriod, onMs);

        if (count == 0) begin
            @(negedge clk);
            checkOutput("busyOneCycle", busy, 0);
        end

        waited = 0;
        while (busy && waited < 3000) begin
            @(negedge clk);
            waited++;
            if (restart && waited == 3 && busy) begin
                start = 1'b1;
                beepCount = CNT_W'(count + 1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        checkOutput("seqEnded", busy, 0);
        checkOutput("trigCount", trigTotal - trig0, expTrig);
        checkOutput("doneCount", doneTotal - done0, expDone);
        checkOutput("errFinal", err, timedOut ? 1 : 0);
        checkOutput("leftFinal", beepsLeft, expLeft);
        checkOutput("periodHeld", buzzPeriod, onMs);
        repeat (2) @(negedge clk);
    endtask

    // Asynchronous reset while the sequencer is sitting in a gap.
    task automatic resetDuringGap();
        int waited;
        seqId++;
        curCount = 3;
        curGap = 2;
        abortBeep = 0;
        buzzEnable = 1'b1;
        @(negedge clk);
        start = 1'b1;
        beepCount = CNT_W'(3);
        onMsIn = 32'd11;
        gapMsIn = 16'd2;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (fallSeq != seqId && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reachedGap", (fallSeq == seqId) ? 1 : 0, 1);
        repeat (5) @(negedge clk);
        checkOutput("busyBeforeReset", busy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstBusy", busy, 0);
        checkOutput("asyncRstTrig", buzzTrig, 0);
        checkOutput("asyncRstDone", done, 0);
        checkOutput("asyncRstErr", err, 0);
        checkOutput("asyncRstLeft", beepsLeft, 0);
        checkOutput("asyncRstPeriod", buzzPeriod, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Main sequence: reset checks, directed scenarios, then randomized sequences.
    initial begin : mainSeq
        int count;
        int gap;
        int abortAt;
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstTrig", buzzTrig, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstLeft", beepsLeft, 0);
        checkOutput("rstPeriod", buzzPeriod, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(3, 32'd5, 2, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(0, 32'd7, 1, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(2, 32'd9, 1, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1, 32'd4, 0, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(4, 32'd6, 3, 1'b1, 2, 1'b0, 1'b0);
        applyStimulus(3, 32'hDEADBEEF, 1, 1'b1, 0, 1'b1, 1'b0);
        applyStimulus(2, 32'd3, 1, 1'b1, 0, 1'b0, 1'b1);
        resetDuringGap();
        applyStimulus(1, 32'd8, 1, 1'b1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            count = $urandom_range(0, 5);
            gap = $urandom_range(0, 3);
            abortAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (count > 0) ? count : 1) : 0;
            applyStimulus(count, $urandom, gap, ($urandom_range(0, 7) != 0), abortAt,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_beep_seq.md
Name: mod_beep_seq

Overview:
- Upstream sequencer for mod_buzzer. On one start request it plays N beeps of a fixed length, separated by programmable silent gaps.
- For each beep it drives the buzzer's trigger and period inputs, then tracks the buzzer's cycle output until that beep completes.
- Sits between the control/register logic and mod_buzzer; all logic runs in the 4 MHz domain.

Parameters:
- simulation, 0, 1 = shortened ms tick (divisor 10 instead of 4000) for fast benches.
- CNT_W, 4, width of the beep-count input and remaining-count output.

Ports:
- clk_4M_i  in  1  4 MHz clock; only clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  level-sampled start request; honoured only in IDLE.
- abort_i  in  1  stop the sequence after the beep in progress.
- beep_count_i  in  CNT_W  number of beeps; 0 = none.
- on_ms_i  in  32  beep length; forwarded to the buzzer period.
- gap_ms_i  in  16  silence between beeps, in ms.
- buzz_cyc_i  in  1  cyc_o from mod_buzzer.
- buzz_trig_o  out  1  trigger to mod_buzzer; single-cycle pulse.
- buzz_period_o  out  32  period_ms to mod_buzzer; held stable while busy.
- busy_o  out  1  high from start acceptance until return to IDLE.
- done_o  out  1  one-cycle pulse on normal completion.
- err_o  out  1  sticky ack-timeout flag; cleared by the next accepted start.
- beeps_left_o  out  CNT_W  beeps not yet triggered.

Behaviour:
- Reset (async, any state): state = IDLE; all outputs 0; latched count/gap registers and counters cleared. A reset mid-beep does not stop the buzzer; the buzzer has its own reset.
- Start acceptance: IDLE and start_i = 1 at edge k.
  - Latch count, on_ms and gap_ms; buzz_period_o <= on_ms_i.
  - Clear err_o; set busy_o at k+1.
  - If count = 0: go to DONE, so done_o pulses at k+1 and no trigger is issued.
  - Otherwise go to TRIG.
- Latched values are used for the whole sequence; later input changes are ignored. start_i while busy is ignored.
- States and transitions:
  - IDLE: wait for start.
  - TRIG: buzz_trig_o = 1 for exactly this cycle; decrement beeps_left_o; clear ack timer; go to WAIT_ACK.
  - WAIT_ACK: wait for buzz_cyc_i = 1, then go to WAIT_END.
    - If buzz_cyc_i stays 0 for ACK_TIMEOUT (15) cycles: set err_o and go to DONE_ERR.
  - WAIT_END: wait for buzz_cyc_i = 0.
    - If abort_i was seen, go to IDLE.
    - Else if beeps_left = 0, go to DONE.
    - Else if gap = 0, go to TRIG.
    - Else go to GAP.
  - GAP: ms tick generator cleared on entry. Count gap_ms ticks; on the final tick go to TRIG, or to IDLE if aborted.
  - DONE: done_o = 1 for one cycle; go to IDLE; busy_o drops with the IDLE entry.
  - DONE_ERR: go to IDLE with no done_o pulse.
- Trigger timing: first buzz_trig_o is high in cycle k+1.
- Gap timing: measured from buzz_cyc_i falling to the next trig is gap_ms × MS_DIV cycles, ±2 cycles.
- Abort:
  - abort_i is registered into a sticky abort flag while busy.
  - In TRIG or WAIT_ACK, the sequence continues to WAIT_END so the buzzer is never left mid-cycle.
  - In GAP, it exits to IDLE on the next edge.
  - An abort ends the sequence with no done_o and no further trigger.
  - abort_i in IDLE has no effect.
- Simultaneous events:
  - In WAIT_END, a buzz_cyc_i fall together with abort_i is treated as aborted.
  - abort_i together with start_i in IDLE: the start is accepted and the abort is ignored.
- Width rules:
  - beeps_left_o saturates at 0.
  - Gap counter is 16 bits and compared for equality with the latched gap; no wrap occurs because gap ≤ 65535.
  - A ms tick is one cycle every MS_DIV cycles from the last clear.

Decomposition:
- Package beep_seq_pkg:
  - enum seq_state_t {IDLE, TRIG, WAIT_ACK, WAIT_END, GAP, DONE, DONE_ERR}.
  - MS_DIV = 4000, MS_DIV_SIM = 10, ACK_TIMEOUT = 15.
- Sub-module mod_ms_tick (params simulation; ports clk_4M_i, rst_i, clr_i, tick_o):
  - 12-bit divider.
  - tick_o pulses when count = div-1, then the count wraps to 0.
  - clr_i forces count to 0 with no tick that cycle.

Test Plan:
1. simulation = 1; count = 3, on_ms = 5, gap_ms = 2, bench buzzer model -> exactly 3 trig pulses; successive trigs separated by cyc-low-to-trig of 20±2 cycles; one done_o; busy_o low after done; err_o = 0.
2. count = 0 with start -> no buzz_trig_o; done_o pulses at k+1; busy_o high for exactly 1 cycle.
3. buzz_cyc_i tied 0, count = 2 -> one trig; err_o set 15 cycles later; no done_o; IDLE. A following start clears err_o.
4. count = 4, gap = 3; abort during the 2nd beep's WAIT_END -> the 2nd beep completes; no 3rd trig; no done_o; beeps_left_o = 2 at abort.
5. start re-asserted while busy, and on_ms_i changed mid-sequence -> no extra trig; buzz_period_o keeps the originally latched value.
6. rst_i asserted asynchronously during GAP -> all outputs 0 immediately (before the next clock edge); after release, a fresh start with count = 1 gives a normal single beep and done_o.
